// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared state encoding and defaults for the instruction-cycle controller
package cpu_ctrl_pkg;

   localparam int CNT_W_DEF = 3;
   localparam int TMO_DEF   = 15;
   localparam int WAIT_W    = 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_DECODE = 3'd2,
      ST_EXEC   = 3'd3,
      ST_INTR   = 3'd4,
      ST_HALT   = 3'd5,
      ST_FAULT  = 3'd6
   } state_t;

endpackage

// File: rtl/cycle_down_counter.sv
// rtl/cycle_down_counter.sv - loadable down-counter with zero flag
// Ports:
//   i_clk      clock
//   i_rst_n    asynchronous active-low reset
//   i_load     load i_load_val (takes priority over i_dec)
//   i_load_val value to load
//   i_dec      decrement, holds at zero
//   o_zero     count is zero
module cycle_down_counter #(
   parameter int W = 3
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_dec,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/instr_cycle_ctrl.sv
// rtl/instr_cycle_ctrl.sv - fetch/decode/execute/interrupt sequencer for the single-issue core
// Ports:
//   clk, clr        clock, asynchronous active-low reset
//   run             keep issuing instructions
//   mem_req/mem_ack instruction fetch handshake
//   ir_load, pc_inc one-cycle pulses in DECODE
//   ex_len,halt_ins decoder results, sampled in DECODE
//   irq/irq_ack     level interrupt request and acknowledge pulse
//   ph_*, halted, fault  one-hot phase indicators (all 0 in IDLE)
module instr_cycle_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int TMO   = TMO_DEF
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             run,
   output logic             mem_req,
   input  logic             mem_ack,
   output logic             ir_load,
   output logic             pc_inc,
   input  logic [CNT_W-1:0] ex_len,
   input  logic             halt_ins,
   input  logic             irq,
   output logic             irq_ack,
   output logic             ph_fetch,
   output logic             ph_decode,
   output logic             ph_exec,
   output logic             ph_int,
   output logic             halted,
   output logic             fault
);

   localparam logic [WAIT_W-1:0] TMO_LAST = WAIT_W'(TMO - 1);

   state_t            r_state;
   state_t            w_next;
   logic [WAIT_W-1:0] r_wait;
   logic              w_wait_last;
   logic              w_exec_last;
   logic [CNT_W-1:0]  w_ex_load_val;

   // Counter holds remaining cycles minus one, so zero marks the last EXEC
   // cycle; ex_len of 0 behaves as 1.
   assign w_ex_load_val = (ex_len == '0) ? '0 : ex_len - CNT_W'(1);

   cycle_down_counter #(.W(CNT_W)) u_exec_cnt (
      .i_clk      (clk),
      .i_rst_n    (clr),
      .i_load     (r_state == ST_DECODE),
      .i_load_val (w_ex_load_val),
      .i_dec      (r_state == ST_EXEC),
      .o_zero     (w_exec_last)
   );

   // Fetch-wait counter: counts FETCH edges without ack, cleared otherwise.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_wait <= '0;
      end else if ((r_state == ST_FETCH) && !mem_ack) begin
         r_wait <= r_wait + WAIT_W'(1);
      end else begin
         r_wait <= '0;
      end
   end

   assign w_wait_last = (r_wait == TMO_LAST);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next    = r_state;
      mem_req   = 1'b0;
      ir_load   = 1'b0;
      pc_inc    = 1'b0;
      irq_ack   = 1'b0;
      ph_fetch  = 1'b0;
      ph_decode = 1'b0;
      ph_exec   = 1'b0;
      ph_int    = 1'b0;
      halted    = 1'b0;
      fault     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (run) w_next = ST_FETCH;
         end
         ST_FETCH: begin
            mem_req  = 1'b1;
            ph_fetch = 1'b1;
            // ack wins over a timeout on the same edge
            if (mem_ack)          w_next = ST_DECODE;
            else if (w_wait_last) w_next = ST_FAULT;
         end
         ST_DECODE: begin
            ir_load   = 1'b1;
            pc_inc    = 1'b1;
            ph_decode = 1'b1;
            w_next    = halt_ins ? ST_HALT : ST_EXEC;
         end
         ST_EXEC: begin
            ph_exec = 1'b1;
            if (w_exec_last) begin
               if (irq)       w_next = ST_INTR;
               else if (!run) w_next = ST_IDLE;
               else           w_next = ST_FETCH;
            end
         end
         ST_INTR: begin
            ph_int  = 1'b1;
            irq_ack = 1'b1;
            w_next  = ST_FETCH;
         end
         ST_HALT: begin
            halted = 1'b1;
            if (irq) w_next = ST_INTR;
         end
         ST_FAULT: begin
            fault = 1'b1;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule

// File: doc/instr_cycle_ctrl.md
Name: instr_cycle_ctrl

Overview:
- Top-level instruction-cycle controller for the single-issue processor.
- Sequences fetch, decode, execute and interrupt-entry phases.
- Handshakes with instruction memory and stretches execute to the per-opcode cycle count from the decoder.
- Handles halt, run gating, interrupts and fetch timeout, and drives phase strobes to datapath, IR and PC.

Parameters:
CNT_W, 3, width of execute-length input and execute counter
TMO, 15, fetch wait cycles without mem_ack before FAULT (1..255)

Ports:
clk  in  1  system clock, all state on rising edge
clr  in  1  asynchronous active-low reset
run  in  1  level; 1 = keep issuing instructions
mem_req  out  1  instruction fetch request
mem_ack  in  1  memory has instruction data valid this cycle
ir_load  out  1  one-cycle pulse, IR captures fetched word
pc_inc  out  1  one-cycle pulse, PC increments
ex_len  in  CNT_W  execute cycles for decoded opcode, sampled in DECODE
halt_ins  in  1  decoded opcode is HALT, sampled in DECODE
irq  in  1  level interrupt request
irq_ack  out  1  one-cycle interrupt acknowledge
ph_fetch  out  1  state == FETCH
ph_decode  out  1  state == DECODE
ph_exec  out  1  state == EXEC
ph_int  out  1  state == INTR
halted  out  1  state == HALT
fault  out  1  state == FAULT, sticky

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, INTR, HALT, FAULT.
- State is registered; all outputs are Moore, decoded from state and registered counters. No combinational input-to-output paths.
- Reset (clr=0, any time, asynchronous):
  - state=IDLE; exec counter and fetch-wait counter = 0.
  - All outputs 0.
  - Mid-instruction reset abandons the instruction with no further pulses.
- IDLE: if run=1, go to FETCH next edge; otherwise stay.
- FETCH:
  - mem_req=1 and ph_fetch=1.
  - Edge with mem_ack=1: go to DECODE and clear the wait counter.
  - Edge with mem_ack=0: wait counter increments. When the counter would reach TMO, go to FAULT.
  - mem_ack=1 on the timeout edge: ack wins.
- DECODE:
  - Exactly 1 cycle; ir_load=1, pc_inc=1, ph_decode=1.
  - Samples halt_ins and ex_len.
  - halt_ins=1: go to HALT.
  - Otherwise go to EXEC and load the exec counter with ex_len, treating 0 as 1.
- EXEC:
  - ph_exec=1 for exactly max(ex_len,1) cycles; the counter decrements each edge.
  - On the last cycle, next state by priority: irq=1 → INTR; run=0 → IDLE; else FETCH.
  - irq is not sampled before the last execute cycle.
- INTR: 1 cycle; ph_int=1, irq_ack=1; then FETCH unconditionally (vector load is the datapath's job).
- HALT:
  - halted=1, mem_req=0.
  - Exit only on irq=1 → INTR; run is ignored.
- FAULT: fault=1, all other outputs 0; exit only via clr.
- Throughput: minimum instruction is 3 cycles (FETCH 1, DECODE 1, EXEC 1), giving back-to-back mem_req at cycles n and n+3.
- Exactly one of ph_fetch, ph_decode, ph_exec, ph_int, halted, fault is 1 outside IDLE; all are 0 in IDLE.
- Counters are saturating-free; TMO ≤ 2^8−1 fixes the wait counter at 8 bits.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - state encoding constants: IDLE=3'd0, FETCH=1, DECODE=2, EXEC=3, INTR=4, HALT=5, FAULT=6;
  - CNT_W default;
  - TMO default.
- One natural sub-module, cycle_down_counter: loadable down-counter with zero flag, reused for the exec counter. The fetch-wait counter stays inline.

Test Plan:
- Reset then run=1, mem_ack tied 1, ex_len=0 → mem_req high at cycles 1,4,7; ir_load/pc_inc pulse at 2,5,8; ph_exec high 1 cycle each.
- ex_len=5, mem_ack after 2 wait cycles → ph_fetch 3 cycles, ph_decode 1, ph_exec exactly 5, then mem_req again.
- irq raised during EXEC cycle 2 of 4 → INTR entered only after cycle 4; irq_ack one pulse; next state FETCH.
- halt_ins=1 in DECODE → halted=1, mem_req=0 for 20 cycles with run=1; irq=1 → irq_ack pulse then FETCH.
- mem_ack held 0, TMO=15 → fault=1 after 15 FETCH cycles and stays 1; mem_ack=1 on the 15th edge instead → DECODE, no fault.
- clr=0 asserted mid-EXEC, asynchronously between edges → all outputs 0 immediately; after release with run=0, stays IDLE.
